// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arb_pkg
// Description : Shared FSM state type and funct3 size codes for dmem_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic [2:0] LB      = 3'b000;
    localparam logic [2:0] LH      = 3'b001;
    localparam logic [2:0] LW      = 3'b010;
    localparam logic [2:0] LBU     = 3'b100;
    localparam logic [2:0] LHU     = 3'b101;
    localparam logic [2:0] INVALID = 3'b111;

    // Stores only exist in signed-size form; unsigned codes are load-only.
    function automatic logic store_size_ok(input logic [2:0] f3);
        return (f3 == LB) || (f3 == LH) || (f3 == LW);
    endfunction

endpackage : dmem_arb_pkg
`default_nettype wire

// File: rtl/dmem_arb_sel.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arb_sel
// Description : Two-requester selector; prio_i picks the winner on conflict
//               (0 = port 0, 1 = port 1). Output is one-hot or zero.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arb_sel (
    input  logic [1:0] req_i,
    input  logic       prio_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = 2'b00;
        if (req_i == 2'b11) begin
            gnt_o = prio_i ? 2'b10 : 2'b01;
        end else begin
            gnt_o = req_i;
        end
    end

endmodule : dmem_arb_sel
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Two-port data-memory arbiter, IDLE -> ACCESS -> RESP sequence,
//               one access per three cycles. Macro DMEM_ARB_RR_EN selects
//               round-robin arbitration; otherwise port 0 has fixed priority.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 32,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [2:0]        p0_funct3,
    input  logic [AWIDTH-1:0] p0_addr,
    input  logic [DWIDTH-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DWIDTH-1:0] p0_rdata,

    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [2:0]        p1_funct3,
    input  logic [AWIDTH-1:0] p1_addr,
    input  logic [DWIDTH-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DWIDTH-1:0] p1_rdata,

    output logic              mem_we,
    output logic [2:0]        mem_funct3,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_wdata,
    input  logic [DWIDTH-1:0] mem_rdata
);

    state_t            state_q, state_d;

    logic [1:0]        w_req;
    logic [1:0]        w_sel_gnt;
    logic              w_prio;
    logic              w_take;
    logic              w_in_range;
    logic              w_store_ok;
    logic              w_resp;

    logic              we_q;
    logic [2:0]        f3_q;
    logic [AWIDTH-1:0] addr_q;
    logic [DWIDTH-1:0] wdata_q;
    logic              port_q;
    logic [DWIDTH-1:0] rdata_q;

    assign w_req  = {p1_req, p0_req};
    assign w_take = (state_q == ST_IDLE) && (|w_sel_gnt);

`ifdef DMEM_ARB_RR_EN
    logic prio_q;

    // After granting port 0 prefer port 1 next time, and vice versa.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_q <= 1'b0;
        end else if (w_take) begin
            prio_q <= w_sel_gnt[0];
        end
    end

    assign w_prio = prio_q;
`else
    assign w_prio = 1'b0;
`endif

    dmem_arb_sel u_sel (
        .req_i  (w_req),
        .prio_i (w_prio),
        .gnt_o  (w_sel_gnt)
    );

    assign p0_gnt = w_take & ~rst & w_sel_gnt[0];
    assign p1_gnt = w_take & ~rst & w_sel_gnt[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign w_in_range = (addr_q < AWIDTH'(DEPTH));
    assign w_store_ok = we_q & store_size_ok(f3_q) & w_in_range;

    always_comb begin
        state_d    = state_q;
        mem_we     = 1'b0;
        mem_funct3 = INVALID;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state_q)
            ST_IDLE: begin
                if (|w_sel_gnt) begin
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                state_d    = ST_RESP;
                mem_we     = w_store_ok;
                mem_funct3 = f3_q;
                mem_addr   = addr_q;
                mem_wdata  = wdata_q;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Command is latched from the winner only; later field changes are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            f3_q    <= INVALID;
            addr_q  <= '0;
            wdata_q <= '0;
            port_q  <= 1'b0;
        end else if (w_take) begin
            if (w_sel_gnt[1]) begin
                we_q    <= p1_we;
                f3_q    <= p1_funct3;
                addr_q  <= p1_addr;
                wdata_q <= p1_wdata;
                port_q  <= 1'b1;
            end else begin
                we_q    <= p0_we;
                f3_q    <= p0_funct3;
                addr_q  <= p0_addr;
                wdata_q <= p0_wdata;
                port_q  <= 1'b0;
            end
        end
    end

    // Stores and out-of-range accesses return zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (state_q == ST_ACCESS) begin
            rdata_q <= (!we_q && w_in_range) ? mem_rdata : '0;
        end
    end

    assign w_resp    = (state_q == ST_RESP);
    assign p0_rvalid = w_resp & ~port_q;
    assign p1_rvalid = w_resp &  port_q;
    assign p0_rdata  = p0_rvalid ? rdata_q : '0;
    assign p1_rdata  = p1_rvalid ? rdata_q : '0;

endmodule : dmem_arbiter
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Self-checking bench for dmem_arbiter (vector table, corner
//               sequences, randomized traffic against a transaction model).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam int DEPTH = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        p0_req, p0_we, p0_gnt, p0_rvalid;
    logic [2:0]  p0_funct3;
    logic [31:0] p0_addr, p0_wdata, p0_rdata;
    logic        p1_req, p1_we, p1_gnt, p1_rvalid;
    logic [2:0]  p1_funct3;
    logic [31:0] p1_addr, p1_wdata, p1_rdata;
    logic        mem_we;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    dmem_arbiter #(.DWIDTH(32), .AWIDTH(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_funct3(p0_funct3), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_funct3(p1_funct3), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .mem_we(mem_we), .mem_funct3(mem_funct3), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural data memory with asynchronous read.
    logic [31:0] mem [DEPTH];
    logic        mem_init;
    assign mem_rdata = (mem_addr < DEPTH) ? mem[mem_addr[4:0]] : 32'hBAD0_BAD0;

    function automatic logic [31:0] init_val(input int i);
        return (i == 5) ? 32'h1234_5678 : (32'hA000_0000 + 32'(i));
    endfunction

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= init_val(i);
        end else if (mem_we && mem_addr < DEPTH) begin
            mem[mem_addr[4:0]] <= mem_wdata;
        end
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input int p, input bit rq, input bit we, input bit [2:0] f3,
                         input bit [31:0] a, input bit [31:0] w);
        if (p == 0) begin
            p0_req = rq; p0_we = we; p0_funct3 = f3; p0_addr = a; p0_wdata = w;
        end else begin
            p1_req = rq; p1_we = we; p1_funct3 = f3; p1_addr = a; p1_wdata = w;
        end
    endtask

    task automatic reset_pulse();
        @(posedge clk); #1;
        rst = 1'b1; mem_init = 1'b1;
        drive(0, 0, 0, 0, 0, 0); drive(1, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        mem_init = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    typedef struct {
        int         port;
        bit         we;
        bit [2:0]   f3;
        bit [31:0]  addr;
        bit [31:0]  wdata;
        bit         exp_we;
        bit [31:0]  exp_rdata;
    } vec_t;

    // One complete transaction: gnt at T, memory cycle at T+1, response at T+2.
    task automatic do_txn(input vec_t v, input int idx);
        logic g_own, g_oth, rv_own, rv_oth;
        logic [31:0] rd_own;
        drive(v.port, 1, v.we, v.f3, v.addr, v.wdata);
        @(negedge clk);
        g_own = (v.port == 0) ? p0_gnt : p1_gnt;
        g_oth = (v.port == 0) ? p1_gnt : p0_gnt;
        chk($sformatf("v%0d gnt_own", idx), 64'(g_own), 64'd1);
        chk($sformatf("v%0d gnt_other", idx), 64'(g_oth), 64'd0);
        @(posedge clk); #1;
        drive(v.port, 0, ~v.we, 3'b010, v.addr + 1, ~v.wdata);
        @(negedge clk);
        chk($sformatf("v%0d mem_we", idx), 64'(mem_we), 64'(v.exp_we));
        chk($sformatf("v%0d mem_addr", idx), 64'(mem_addr), 64'(v.addr));
        chk($sformatf("v%0d mem_funct3", idx), 64'(mem_funct3), 64'(v.f3));
        chk($sformatf("v%0d mem_wdata", idx), 64'(mem_wdata), 64'(v.wdata));
        chk($sformatf("v%0d early_rvalid", idx), 64'({p0_rvalid, p1_rvalid}), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        rv_own = (v.port == 0) ? p0_rvalid : p1_rvalid;
        rv_oth = (v.port == 0) ? p1_rvalid : p0_rvalid;
        rd_own = (v.port == 0) ? p0_rdata  : p1_rdata;
        chk($sformatf("v%0d rvalid_own", idx), 64'(rv_own), 64'd1);
        chk($sformatf("v%0d rvalid_other", idx), 64'(rv_oth), 64'd0);
        chk($sformatf("v%0d rdata", idx), 64'(rd_own), 64'(v.exp_rdata));
        chk($sformatf("v%0d resp_mem_idle", idx), 64'({mem_we, mem_funct3}), 64'h7);
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        vec_t tbl[9];
        int   g_port[$];
        int   g_cyc[$];

        // ---------------- reset state ----------------
        rst = 1'b1; mem_init = 1'b1;
        drive(0, 1, 1, 3'b010, 32'd4, 32'hFFFF_FFFF);
        drive(1, 1, 0, 3'b010, 32'd6, 32'h0);
        @(posedge clk); #1;
        mem_init = 1'b0;
        @(negedge clk);
        chk("rst gnt", 64'({p0_gnt, p1_gnt}), 64'd0);
        chk("rst rvalid", 64'({p0_rvalid, p1_rvalid}), 64'd0);
        chk("rst rdata", 64'({p0_rdata, p1_rdata}), 64'd0);
        chk("rst mem_we", 64'(mem_we), 64'd0);
        chk("rst mem_funct3", 64'(mem_funct3), 64'h7);
        chk("rst mem_addr_wdata", 64'({mem_addr, mem_wdata}), 64'd0);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0); drive(1, 0, 0, 0, 0, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // ---------------- vector table ----------------
        tbl[0] = '{0, 0, 3'b010, 32'd5,  32'h0,         0, 32'h1234_5678};
        tbl[1] = '{1, 1, 3'b010, 32'd3,  32'hDEAD_BEEF, 1, 32'h0};
        tbl[2] = '{1, 0, 3'b010, 32'd3,  32'h0,         0, 32'hDEAD_BEEF};
        tbl[3] = '{0, 1, 3'b100, 32'd2,  32'h1111_1111, 0, 32'h0};
        tbl[4] = '{0, 1, 3'b010, 32'd40, 32'h2222_2222, 0, 32'h0};
        tbl[5] = '{1, 0, 3'b000, 32'd2,  32'h0,         0, 32'hA000_0002};
        tbl[6] = '{0, 0, 3'b010, 32'd40, 32'h0,         0, 32'h0};
        tbl[7] = '{0, 1, 3'b001, 32'd31, 32'h0000_CAFE, 1, 32'h0};
        tbl[8] = '{1, 0, 3'b101, 32'd31, 32'h0,         0, 32'h0000_CAFE};
        for (int i = 0; i < 9; i++) do_txn(tbl[i], i);

        // ---------------- conflict: both held for 6 cycles ----------------
        reset_pulse();
        drive(0, 1, 0, 3'b010, 32'd1, 32'h0);
        drive(1, 1, 0, 3'b010, 32'd2, 32'h0);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (p0_gnt) begin g_port.push_back(0); g_cyc.push_back(c); end
            if (p1_gnt) begin g_port.push_back(1); g_cyc.push_back(c); end
            @(posedge clk); #1;
        end
        drive(0, 0, 0, 0, 0, 0); drive(1, 0, 0, 0, 0, 0);
        chk("conflict n_gnt", 64'(g_port.size()), 64'd2);
        if (g_port.size() == 2) begin
            chk("conflict first_port", 64'(g_port[0]), 64'd0);
`ifdef DMEM_ARB_RR_EN
            chk("conflict second_port", 64'(g_port[1]), 64'd1);
`else
            chk("conflict second_port", 64'(g_port[1]), 64'd0);
`endif
            chk("conflict first_cyc", 64'(g_cyc[0]), 64'd0);
            chk("conflict second_cyc", 64'(g_cyc[1]), 64'd3);
        end
        @(posedge clk); #1;

        // ---------------- reset during ACCESS of a store ----------------
        drive(0, 1, 1, 3'b010, 32'd7, 32'h5555_AAAA);
        @(negedge clk);
        chk("mid_rst gnt", 64'(p0_gnt), 64'd1);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("mid_rst access_we", 64'(mem_we), 64'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst we_after_rst", 64'(mem_we), 64'd0);
        chk("mid_rst funct3_after_rst", 64'(mem_funct3), 64'h7);
        @(posedge clk); #1;
        chk("mid_rst no_rvalid", 64'({p0_rvalid, p1_rvalid}), 64'd0);
        rst = 1'b0;
        drive(1, 1, 0, 3'b010, 32'd7, 32'h0);
        @(negedge clk);
        chk("mid_rst regrant", 64'({p0_gnt, p1_gnt}), 64'b01);
        chk("mid_rst no_rvalid2", 64'({p0_rvalid, p1_rvalid}), 64'd0);
        @(posedge clk); #1;
        drive(1, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("mid_rst load_we", 64'(mem_we), 64'd0);
        chk("mid_rst no_rvalid3", 64'(p0_rvalid), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_rst rvalid", 64'({p0_rvalid, p1_rvalid}), 64'b01);
        chk("mid_rst mem_unchanged", 64'(p1_rdata), 64'hA000_0007);

        // ---------------- randomized traffic vs transaction model ----------------
        reset_pulse();
        begin : rnd
            logic [31:0] shadow [DEPTH];
            bit          pend [2];
            bit          pwe  [2];
            bit [2:0]    pf3  [2];
            bit [31:0]   pa   [2];
            bit [31:0]   pw   [2];
            bit          got  [2];
            bit          act;
            int          gcyc;
            int          t_port;
            bit          t_we;
            bit [2:0]    t_f3;
            bit [31:0]   t_addr, t_wdata, t_rdata;
`ifdef DMEM_ARB_RR_EN
            int          prefer;
`endif
            bit          eg [2];
            bit          erv [2];
            bit [31:0]   erd [2];
            bit          em_we;
            bit [2:0]    em_f3;
            bit [31:0]   em_addr, em_wd;
            bit [2:0]    f3_pool [7];
            int          w;

            f3_pool = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110};
            for (int i = 0; i < DEPTH; i++) shadow[i] = init_val(i);
            for (int p = 0; p < 2; p++) begin pend[p] = 0; got[p] = 0; end
            act = 0; gcyc = -10;
`ifdef DMEM_ARB_RR_EN
            prefer = 0;
`endif
            for (int cyc = 0; cyc < 800; cyc++) begin
                // requester behaviour: new requests, occasional early withdrawal
                for (int p = 0; p < 2; p++) begin
                    if (got[p]) pend[p] = 0;
                    else if (pend[p] && ($urandom % 20 == 0)) pend[p] = 0;
                    if (!pend[p] && ($urandom % 3 == 0)) begin
                        pend[p] = 1;
                        pwe[p]  = 1'($urandom % 2);
                        pf3[p]  = f3_pool[$urandom % 7];
                        pa[p]   = 32'($urandom_range(0, 39));
                        pw[p]   = $urandom;
                    end
                    drive(p, pend[p], pwe[p], pf3[p], pa[p], pw[p]);
                end
                @(negedge clk);
                for (int p = 0; p < 2; p++) begin eg[p] = 0; erv[p] = 0; erd[p] = 0; end
                em_we = 0; em_f3 = 3'b111; em_addr = 0; em_wd = 0;
                if (act && cyc == gcyc + 1) begin
                    em_f3 = t_f3; em_addr = t_addr; em_wd = t_wdata;
                    em_we = t_we && (t_addr < DEPTH) && (t_f3 <= 3'b010);
                    t_rdata = (!t_we && t_addr < DEPTH) ? shadow[t_addr[4:0]] : 32'h0;
                    if (em_we) shadow[t_addr[4:0]] = t_wdata;
                end
                if (act && cyc == gcyc + 2) begin
                    erv[t_port] = 1; erd[t_port] = t_rdata;
                end
                if ((!act || cyc >= gcyc + 3) && (pend[0] || pend[1])) begin
`ifdef DMEM_ARB_RR_EN
                    w = (pend[0] && pend[1]) ? prefer : (pend[0] ? 0 : 1);
                    prefer = 1 - w;
`else
                    w = pend[0] ? 0 : 1;
`endif
                    eg[w] = 1; act = 1; gcyc = cyc; t_port = w;
                    t_we = pwe[w]; t_f3 = pf3[w]; t_addr = pa[w]; t_wdata = pw[w];
                end
                got[0] = eg[0]; got[1] = eg[1];
                chk($sformatf("rnd c%0d gnt", cyc), 64'({p1_gnt, p0_gnt}), 64'({eg[1], eg[0]}));
                chk($sformatf("rnd c%0d rvalid", cyc), 64'({p1_rvalid, p0_rvalid}), 64'({erv[1], erv[0]}));
                chk($sformatf("rnd c%0d p0_rdata", cyc), 64'(p0_rdata), 64'(erd[0]));
                chk($sformatf("rnd c%0d p1_rdata", cyc), 64'(p1_rdata), 64'(erd[1]));
                chk($sformatf("rnd c%0d mem_ctl", cyc), 64'({mem_we, mem_funct3}), 64'({em_we, em_f3}));
                chk($sformatf("rnd c%0d mem_addr", cyc), 64'(mem_addr), 64'(em_addr));
                chk($sformatf("rnd c%0d mem_wdata", cyc), 64'(mem_wdata), 64'(em_wd));
                @(posedge clk); #1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_dmem_arbiter
`default_nettype wire

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter DWIDTH, default 32, data width.
REQ-002 SHALL have parameter AWIDTH, default 32, address width.
REQ-003 SHALL have parameter DEPTH, default 32, number of data-memory words.
REQ-004 SHALL have port clk  input  1  single clock, all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports p0_req / p1_req  input  1  access request.
REQ-007 SHALL have ports p0_we / p1_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have ports p0_funct3 / p1_funct3  input  3  size code: 000 byte, 001 half, 010 word, 100 byte unsigned, 101 half unsigned.
REQ-009 SHALL have ports p0_addr / p1_addr  input  AWIDTH  word address.
REQ-010 SHALL have ports p0_wdata / p1_wdata  input  DWIDTH  store data.
REQ-011 SHALL have ports p0_gnt / p1_gnt  output  1  request accepted this cycle.
REQ-012 SHALL have ports p0_rvalid / p1_rvalid  output  1  completion pulse.
REQ-013 SHALL have ports p0_rdata / p1_rdata  output  DWIDTH  load result.
REQ-014 SHALL have ports mem_we  output  1, mem_funct3  output  3, mem_addr  output  AWIDTH, mem_wdata  output  DWIDTH  to data memory.
REQ-015 SHALL have port mem_rdata  input  DWIDTH  asynchronous read data from data memory.

Function
REQ-016 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE.
REQ-017 In IDLE with any pN_req high, it SHALL assert the winner's pN_gnt combinationally for exactly that cycle, latch we/funct3/addr/wdata/port-id, and go to ACCESS. With no request, it SHALL stay in IDLE.
REQ-018 In ACCESS, mem_* SHALL be driven from the latched command. mem_we SHALL equal the latched we for that single cycle. mem_rdata SHALL be captured at the closing edge.
REQ-019 In RESP, only the owning port's rvalid SHALL be 1 for one cycle, with rdata = captured value. Stores also pulse rvalid, with rdata = 0.
REQ-020 Latency: gnt in cycle T SHALL give rvalid in cycle T+2. Peak throughput SHALL be one access per 3 cycles.
REQ-021 Outside ACCESS: mem_we = 0, mem_funct3 = 3'b111, mem_addr = 0, mem_wdata = 0.
REQ-022 A requester SHALL hold req and fields stable until gnt. Dropping req before gnt is legal and commits nothing. Fields after gnt SHALL be ignored.
REQ-023 No gnt SHALL be issued while in ACCESS or RESP. Requests arriving then wait.
REQ-024 Store with funct3 outside {000,001,010}, or any access with addr >= DEPTH, SHALL keep mem_we = 0, return rdata = 0, and still pulse rvalid.
REQ-025 Simultaneous requests SHALL be resolved per REQ-029.
REQ-026 Non-owning port rvalid/rdata SHALL be 0.

Reset
REQ-027 While rst is high: FSM = IDLE; all gnt, rvalid = 0; rdata = 0; mem_* at REQ-021 values; latched command cleared; round-robin pointer = port 0 preferred.
REQ-028 Reset during ACCESS or RESP SHALL abort the access: no write is issued after rst asserts, and no rvalid is produced.

Configuration
REQ-029 Macro DMEM_ARB_RR_EN:
- Defined: round-robin. The port not granted last wins on conflict. The pointer updates on each gnt.
- Undefined: fixed priority, p0 always wins. No pointer register exists.

Structure
REQ-030 Package dmem_arb_pkg SHALL hold the FSM state typedef and the funct3 constants (LB, LH, LW, LBU, LHU, INVALID = 3'b111).
REQ-031 Arbitration (request pair + pointer -> one-hot grant) SHALL be sub-module dmem_arb_sel. The FSM, command latch and response logic SHALL stay in dmem_arbiter.

Verification
REQ-032 Load: p0 load, funct3 010, addr 5, mem word 0x1234_5678 -> p0_gnt at T, mem_addr 5 at T+1, p0_rvalid with rdata 0x1234_5678 at T+2.
REQ-033 Store: p1 store, funct3 010, addr 3, wdata 0xDEAD_BEEF -> mem_we = 1 exactly at T+1, p1_rvalid at T+2; a following p1 load of addr 3 returns 0xDEAD_BEEF.
REQ-034 Conflict: both req held for 6 cycles:
- With DMEM_ARB_RR_EN, grant order is p0, p1.
- Without DMEM_ARB_RR_EN, grant order is p0, p0.
REQ-035 Illegal and out-of-range accesses: store funct3 100 to addr 2, or store to addr 40 -> mem_we never 1, rvalid pulses, rdata 0, memory unchanged.
REQ-036 Mid-access reset: rst pulsed during ACCESS of a store -> no later mem_we, no rvalid, FSM in IDLE, a new request is granted on the first cycle after rst falls.
